sbm_digitized_hs: RTL and testbench

Parametrised digit-serial shift-and-add multiplier, c = a * b, the next generation of the sbm_digitized family. It replaces the free-running controller with a latched-operand valid/ready handshake on input and output. It handles SIZEB values that are not a multiple of the digit width and can optionally skip zero digits. It sits in the large-multiplier library as a drop-in area-optimised multiplier for wide operands.

---
 rtl/sbm_pkg.sv | 20 ++
 rtl/sbm_digit_unit.sv | 45 ++++
 rtl/sbm_digitized_hs.sv | 148 ++++++++++++++
 tb/tb_sbm_digitized_hs.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sbm_pkg.sv
// Shared state encoding and sizing helpers for the digit-serial multiplier family.
package sbm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int ndig(input int sizeb, input int digit);
        return (sizeb + digit - 1) / digit;
    endfunction

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sbm_digit_unit.sv
// Bit-serial a * digit: one bit of the digit per cycle while start is held.
// Latency: DIGIT cycles per digit, done is high during the last of them.
// Backpressure: none; the controller simply drops start to pause the unit.
module sbm_digit_unit
    import sbm_pkg::*;
#(
    parameter int SIZEA = 64,
    parameter int DIGIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   start,
    input  logic [SIZEA-1:0]       a,
    input  logic [DIGIT-1:0]       digit,
    output logic [SIZEA+DIGIT-1:0] pp,
    output logic                   done
);

    localparam int JW = cnt_w(DIGIT);
    localparam int PW = SIZEA + DIGIT;

    logic [JW-1:0] j;
    logic [PW-1:0] a_ext;

    assign a_ext = PW'(a);
    assign done  = start && (j == JW'(DIGIT - 1));

    // pp never exceeds a * (2^DIGIT - 1), so PW bits cannot overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j  <= '0;
            pp <= '0;
        end else if (clr) begin
            j  <= '0;
            pp <= '0;
        end else if (start) begin
            if (digit[j]) begin
                pp <= pp + (a_ext << j);
            end
            j <= done ? '0 : j + JW'(1);
        end
    end

endmodule

// File: rtl/sbm_digitized_hs.sv
// Digit-serial shift-and-add multiplier c = a * b with valid/ready on both sides.
// Latency: NDIG*(DIGIT+1) edges from accept to out_valid (fewer with SKIP_ZERO).
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module sbm_digitized_hs
    import sbm_pkg::*;
#(
    parameter int SIZEA     = 64,
    parameter int SIZEB     = 64,
    parameter int DIGIT     = 4,
    parameter int SKIP_ZERO = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIZEA-1:0]       a,
    input  logic [SIZEB-1:0]       b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZEA+SIZEB-1:0] c,
    output logic                   busy
);

    localparam int NDIG = ndig(SIZEB, DIGIT);
    localparam int BPAD = NDIG * DIGIT;
    localparam int AW   = SIZEA + BPAD;
    localparam int CW   = SIZEA + SIZEB;
    localparam int KW   = cnt_w(NDIG);
    localparam int PW   = SIZEA + DIGIT;

    if (DIGIT < 1 || DIGIT > SIZEB) begin : g_bad_digit
        $error("sbm_digitized_hs: DIGIT must lie in 1..SIZEB");
    end

    state_t          state, state_nxt;
    logic [SIZEA-1:0] a_l;
    logic [BPAD-1:0]  b_l;
    logic [AW-1:0]    acc, acc_sum;
    logic [KW-1:0]    k;
    logic [PW-1:0]    pp;
    logic [DIGIT-1:0] cur_dig, nxt_dig, first_dig;
    logic             last, du_done;
    logic             accept, du_start, du_clr, acc_en;

    assign in_ready  = (state == IDLE);
    assign cur_dig   = DIGIT'(b_l >> (DIGIT * k));
    assign nxt_dig   = DIGIT'(b_l >> (DIGIT * (k + 1)));
    assign first_dig = DIGIT'(b);
    assign last      = (k == KW'(NDIG - 1));
    assign acc_sum   = acc + (AW'(pp) << (DIGIT * k));

    sbm_digit_unit #(
        .SIZEA (SIZEA),
        .DIGIT (DIGIT)
    ) u_digit (
        .clk   (clk),
        .rst   (rst),
        .clr   (du_clr),
        .start (du_start),
        .a     (a_l),
        .digit (cur_dig),
        .pp    (pp),
        .done  (du_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero digit with SKIP_ZERO goes straight to ACC; pp is already cleared there.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        du_start  = 1'b0;
        du_clr    = 1'b0;
        acc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    du_clr    = 1'b1;
                    state_nxt = (SKIP_ZERO != 0 && first_dig == '0) ? ACC : MUL;
                end
            end
            MUL: begin
                du_start = 1'b1;
                if (du_done) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                acc_en = 1'b1;
                du_clr = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end else if (SKIP_ZERO != 0 && nxt_dig == '0) begin
                    state_nxt = ACC;
                end else begin
                    state_nxt = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The bits of acc above CW are always zero, so truncating into c is lossless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_l       <= '0;
            b_l       <= '0;
            acc       <= '0;
            k         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (accept) begin
                a_l <= a;
                b_l <= BPAD'(b);
                acc <= '0;
                k   <= '0;
            end
            if (acc_en) begin
                acc <= acc_sum;
                if (last) begin
                    c         <= CW'(acc_sum);
                    out_valid <= 1'b1;
                end else begin
                    k <= k + KW'(1);
                end
            end
            if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sbm_digitized_hs.sv
// Directed and randomized checks of sbm_digitized_hs over several geometries against an arithmetic model.
module tb_sbm_digitized_hs;

    localparam int NI = 7;
    localparam int SA [NI] = '{8, 8, 8, 64, 64, 64, 64};
    localparam int SB [NI] = '{8, 6, 8, 64, 64, 64, 64};
    localparam int DG [NI] = '{4, 4, 4, 1, 3, 8, 64};
    localparam int SK [NI] = '{0, 0, 1, 0, 0, 0, 0};

    logic         clk;
    logic         rst_n;
    logic         iv   [NI];
    logic         ordy [NI];
    logic [63:0]  av   [NI];
    logic [63:0]  bv   [NI];
    logic         irdy [NI];
    logic         ov   [NI];
    logic         bsy  [NI];
    logic [127:0] cv   [NI];

    int n_tests;
    int n_fail;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [SA[g]+SB[g]-1:0] c_w;
        sbm_digitized_hs #(
            .SIZEA     (SA[g]),
            .SIZEB     (SB[g]),
            .DIGIT     (DG[g]),
            .SKIP_ZERO (SK[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (irdy[g]),
            .a         (av[g][SA[g]-1:0]),
            .b         (bv[g][SB[g]-1:0]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .c         (c_w),
            .busy      (bsy[g])
        );
        assign cv[g] = 128'(c_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int id, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, id, obs, exp);
        end
    endtask

    // One full transaction: idle gap, accept, run to out_valid, hold under backpressure, handshake.
    task automatic do_op(input int id, input logic [63:0] a_v, input logic [63:0] b_v,
                         input int gap, input int hold);
        logic [63:0]  am, bm, dig, dmask;
        logic [127:0] exp_c;
        int           nd, lat, cyc;
        bit           busy_bad, hold_bad;

        am    = a_v & ((64'd1 << SA[id]) - 64'd1);
        bm    = b_v & ((64'd1 << SB[id]) - 64'd1);
        exp_c = {64'd0, am} * {64'd0, bm};
        dmask = (64'd1 << DG[id]) - 64'd1;
        nd    = (SB[id] + DG[id] - 1) / DG[id];
        lat   = 0;
        for (int i = 0; i < nd; i++) begin
            dig = (bm >> (i * DG[id])) & dmask;
            lat += (SK[id] != 0 && dig == 64'd0) ? 1 : DG[id] + 1;
        end

        for (int i = 0; i < gap; i++) begin
            ordy[id] = 1'($urandom);
            @(posedge clk); #1;
        end
        ordy[id] = 1'b0;
        chk("idle_in_ready", id, irdy[id], 1);

        iv[id] = 1'b1;
        av[id] = a_v;
        bv[id] = b_v;
        @(posedge clk); #1;

        busy_bad = 0;
        cyc = 0;
        while (ov[id] !== 1'b1 && cyc < 4000) begin
            if (bsy[id] !== 1'b1 || irdy[id] !== 1'b0) busy_bad = 1;
            iv[id]   = 1'($urandom);
            av[id]   = {$urandom, $urandom};
            bv[id]   = {$urandom, $urandom};
            ordy[id] = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        iv[id]   = 1'b0;
        ordy[id] = 1'b0;
        chk("out_valid_seen", id, ov[id], 1);
        chk("latency", id, cyc, lat);
        chk("product", id, cv[id], exp_c);
        chk("busy_while_running", id, busy_bad, 0);
        chk("busy_in_done", id, bsy[id], 1);

        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            iv[id] = 1'($urandom);
            av[id] = {$urandom, $urandom};
            @(posedge clk); #1;
            if (ov[id] !== 1'b1 || cv[id] !== exp_c || irdy[id] !== 1'b0) hold_bad = 1;
        end
        iv[id] = 1'b0;
        if (hold > 0) chk("hold_stable", id, hold_bad, 0);

        ordy[id] = 1'b1;
        @(posedge clk); #1;
        ordy[id] = 1'b0;
        chk("post_hs_valid", id, ov[id], 0);
        chk("post_hs_ready", id, irdy[id], 1);
        chk("post_hs_c_kept", id, cv[id], exp_c);
    endtask

    initial begin
        logic [63:0] ra, rb;
        int          nv;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < NI; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
            av[i]   = '0;
            bv[i]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("reset_c", i, cv[i], 0);
            chk("reset_out_valid", i, ov[i], 0);
            chk("reset_busy", i, bsy[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) chk("reset_in_ready", i, irdy[i], 1);

        do_op(0, 64'hFF, 64'hFF, 0, 0);
        do_op(1, 64'h03, 64'h3F, 0, 0);
        do_op(2, 64'h12, 64'h0F, 0, 0);
        do_op(2, 64'h12, 64'h00, 0, 0);
        do_op(0, 64'hA5, 64'h3C, 0, 5);
        do_op(0, 64'h5A, 64'h77, 0, 0);

        iv[0] = 1'b1;
        av[0] = 64'hFF;
        bv[0] = 64'hFF;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("abort_c", 0, cv[0], 0);
        chk("abort_out_valid", 0, ov[0], 0);
        chk("abort_busy", 0, bsy[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", 0, irdy[0], 1);
        chk("abort_no_valid", 0, ov[0], 0);
        do_op(0, 64'd5, 64'd7, 0, 0);

        for (int id = 0; id < NI; id++) begin
            nv = (id < 3) ? 60 : 100;
            for (int v = 0; v < nv; v++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (v == 0) begin
                    ra = '1;
                    rb = '1;
                end else if (v == 1) begin
                    rb = '0;
                end else if ($urandom_range(0, 2) == 0) begin
                    rb = rb & {$urandom, $urandom} & {$urandom, $urandom};
                end
                do_op(id, ra, rb, $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
